pixel_capture_engine: RTL and testbench
=======================================

PIXEL_CAPTURE_ENGINE -- requirements
Module: pixel_capture_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, camera data bus width.
REQ-002 SHALL have parameter H_WIDTH, default 640, sensor active pixels per line.
REQ-003 SHALL have parameter V_WIDTH, default 480, sensor active lines per frame.
REQ-004 SHALL have parameter DECIM, default 1 (legal 1/2/4), decimation factor in both axes.
REQ-005 SHALL derive localparams HA_W = $clog2(H_WIDTH/DECIM) and VA_W = $clog2(V_WIDTH/DECIM).
REQ-006 Ports: i_clk in 1, single system clock; i_n_reset in 1, asynchronous active-low reset.
REQ-007 Ports: i_start_capture in 1, start/arm pulse; i_stop in 1, abort to IDLE; i_continuous in 1, re-arm automatically after each frame.
REQ-008 Ports: i_fmt in 2, 0=RGB565, 1=RGB555, 2=RGB444, 3=reserved (treated as RGB565); i_swap_bytes in 1, byte order swap.
REQ-009 Ports: i_PCLK, i_VS, i_HS in 1 each, camera timing (asynchronous to i_clk); i_DATA in DATA_WIDTH, camera data.
REQ-010 Ports: o_en_xclk out 1, camera clock enable; o_state out 6, one-hot state.
REQ-011 Ports: o_pixel_data out 16, RGB565 pixel; o_h_addr out HA_W; o_v_addr out VA_W; o_valid out 1, one-cycle write strobe.
REQ-012 Ports: o_frame_done out 1, one-cycle pulse; o_frame_cnt out 8, completed frames; o_line_err out 1, sticky error flag.

Function
REQ-013 i_PCLK, i_HS, i_VS SHALL pass a 2-flop synchroniser then a rising/falling edge detector; i_DATA SHALL be delayed by the same 2 stages so it is sampled aligned with the detected PCLK rising edge.
REQ-014 States (one-hot): IDLE, WAIT_VS_FALL, WAIT_HREF, BYTE0, BYTE1, FRAME_DONE.
REQ-015 IDLE -> WAIT_VS_FALL on i_start_capture; o_en_xclk set to 1 on that transition and held until i_stop.
REQ-016 WAIT_VS_FALL -> WAIT_HREF on VS falling edge; clears line and pixel counters and o_line_err.
REQ-017 WAIT_HREF: VS rising edge -> FRAME_DONE; HREF rising edge -> BYTE0.
REQ-018 BYTE0: PCLK rise -> capture byte A, go BYTE1; HREF fall -> end line, go WAIT_HREF.
REQ-019 BYTE1: PCLK rise -> capture byte B, form pixel, go BYTE0; HREF fall -> set o_line_err (odd byte count), end line, go WAIT_HREF.
REQ-020 Raw word P = {A,B}, or {B,A} when i_swap_bytes=1; i_fmt and i_swap_bytes SHALL be latched on VS fall and held for the frame.
REQ-021 RGB565: out = P. RGB555: R=P[14:10], G={P[9:5],P[9]}, B=P[4:0]. RGB444: R={P[11:8],P[11]}, G={P[7:4],P[7:6]}, B={P[3:0],P[3]}.
REQ-022 Source column counter hc and line counter vc SHALL count every pixel/line; a pixel SHALL be written only if hc%DECIM==0, vc%DECIM==0, hc<H_WIDTH, vc<V_WIDTH.
REQ-023 Written pixel: o_h_addr=hc/DECIM, o_v_addr=vc/DECIM, o_valid high exactly 1 cycle, 1 i_clk after the synchronised PCLK edge that captured byte B.
REQ-024 Line end (HREF fall) with hc != H_WIDTH SHALL set o_line_err; hc >= H_WIDTH beyond capacity SHALL be dropped silently apart from this flag.
REQ-025 Entering FRAME_DONE SHALL pulse o_frame_done 1 cycle and increment o_frame_cnt (wraps 255->0); vc != V_WIDTH at this point SHALL set o_line_err.
REQ-026 FRAME_DONE -> WAIT_VS_FALL immediately if i_continuous=1, else on i_start_capture.
REQ-027 i_stop SHALL, from any state, return to IDLE next cycle, clear o_en_xclk and suppress o_valid; i_stop dominates i_start_capture when simultaneous.
REQ-028 VS rise and HREF fall on the same cycle: line end processed first, then FRAME_DONE.
REQ-029 Unreachable state encodings SHALL recover to IDLE.

Reset
REQ-030 On i_n_reset=0 (asynchronous): state IDLE, all outputs 0, counters 0, synchronisers 0; first capture requires new i_start_capture.
REQ-031 Reset asserted mid-frame SHALL abort with no further o_valid, no o_frame_done.

Verification
REQ-032 RGB565, DECIM=1, H=4,V=2, bytes 0x12,0x34 per pixel -> 8 o_valid, data 0x1234, addrs (0..3,0..1), one o_frame_done, o_frame_cnt=1, o_line_err=0.
REQ-033 i_fmt=2, bytes 0x0F,0x8C -> o_pixel_data {11111,100010,11001}=0xFC59; i_swap_bytes=1 with 0x8C,0x0F -> same.
REQ-034 DECIM=2, H=8,V=4 -> 8 writes, o_h_addr 0..3, o_v_addr 0..1, only even source columns/lines.
REQ-035 Line with 7 bytes -> o_line_err=1 after HREF fall, remaining lines still captured; cleared at next VS fall.
REQ-036 i_continuous=1 over 3 frames -> o_frame_cnt=3, no i_start_capture needed; i_stop mid-line -> IDLE, o_en_xclk=0, no further o_valid.
REQ-037 i_n_reset pulsed mid-line -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/pixel_capture_engine_if.sv
// rtl/pixel_capture_engine_if.sv - control, camera and pixel-write bundle for pixel_capture_engine
interface pixel_capture_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int H_WIDTH    = 640,
    parameter int V_WIDTH    = 480,
    parameter int DECIM      = 1
);
    localparam int HA_W = $clog2(H_WIDTH / DECIM);
    localparam int VA_W = $clog2(V_WIDTH / DECIM);

    logic                  i_start_capture;
    logic                  i_stop;
    logic                  i_continuous;
    logic [1:0]            i_fmt;
    logic                  i_swap_bytes;
    logic                  i_PCLK;
    logic                  i_VS;
    logic                  i_HS;
    logic [DATA_WIDTH-1:0] i_DATA;
    logic                  o_en_xclk;
    logic [5:0]            o_state;
    logic [15:0]           o_pixel_data;
    logic [HA_W-1:0]       o_h_addr;
    logic [VA_W-1:0]       o_v_addr;
    logic                  o_valid;
    logic                  o_frame_done;
    logic [7:0]            o_frame_cnt;
    logic                  o_line_err;

    modport master (
        output i_start_capture, i_stop, i_continuous, i_fmt, i_swap_bytes,
        output i_PCLK, i_VS, i_HS, i_DATA,
        input  o_en_xclk, o_state, o_pixel_data, o_h_addr, o_v_addr,
        input  o_valid, o_frame_done, o_frame_cnt, o_line_err
    );

    modport slave (
        input  i_start_capture, i_stop, i_continuous, i_fmt, i_swap_bytes,
        input  i_PCLK, i_VS, i_HS, i_DATA,
        output o_en_xclk, o_state, o_pixel_data, o_h_addr, o_v_addr,
        output o_valid, o_frame_done, o_frame_cnt, o_line_err
    );
endinterface

// File: rtl/pixel_capture_engine.sv
// rtl/pixel_capture_engine.sv - DVP camera capture: sync, byte pairing, RGB565 conversion, decimated writes
module pixel_capture_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int H_WIDTH    = 640,
    parameter int V_WIDTH    = 480,
    parameter int DECIM      = 1
) (
    input  logic                  i_clk,
    input  logic                  i_n_reset,
    pixel_capture_engine_if.slave bus
);
    localparam int HA_W   = $clog2(H_WIDTH / DECIM);
    localparam int VA_W   = $clog2(V_WIDTH / DECIM);
    localparam int DEC_SH = $clog2(DECIM);
    localparam logic [15:0] DEC_MASK = 16'(DECIM - 1);
    localparam logic [15:0] H_LIM    = 16'(H_WIDTH);
    localparam logic [15:0] V_LIM    = 16'(V_WIDTH);

    localparam logic [5:0] S_IDLE         = 6'b000001;
    localparam logic [5:0] S_WAIT_VS_FALL = 6'b000010;
    localparam logic [5:0] S_WAIT_HREF    = 6'b000100;
    localparam logic [5:0] S_BYTE0        = 6'b001000;
    localparam logic [5:0] S_BYTE1        = 6'b010000;
    localparam logic [5:0] S_FRAME_DONE   = 6'b100000;

    logic [1:0]            pclk_sync, hs_sync, vs_sync;
    logic                  pclk_prev, hs_prev, vs_prev;
    logic [DATA_WIDTH-1:0] data_d1, data_d2;

    logic [5:0]      state;
    logic            en_xclk, valid, frame_done, line_err;
    logic [7:0]      frame_cnt, byte_a;
    logic [15:0]     pixel_data, hc, vc;
    logic [HA_W-1:0] h_addr;
    logic [VA_W-1:0] v_addr;
    logic [1:0]      fmt_l;
    logic            swap_l;

    // Data rides the same two-stage delay as PCLK so it lines up with the detected rise
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            pclk_sync <= '0;
            hs_sync   <= '0;
            vs_sync   <= '0;
            pclk_prev <= 1'b0;
            hs_prev   <= 1'b0;
            vs_prev   <= 1'b0;
            data_d1   <= '0;
            data_d2   <= '0;
        end else begin
            pclk_sync <= {pclk_sync[0], bus.i_PCLK};
            hs_sync   <= {hs_sync[0], bus.i_HS};
            vs_sync   <= {vs_sync[0], bus.i_VS};
            pclk_prev <= pclk_sync[1];
            hs_prev   <= hs_sync[1];
            vs_prev   <= vs_sync[1];
            data_d1   <= bus.i_DATA;
            data_d2   <= data_d1;
        end
    end

    logic        pclk_rise, hs_rise, hs_fall, vs_rise, vs_fall;
    logic [7:0]  cur_byte;
    logic [15:0] raw, conv, hc_inc, vc_inc;
    logic        wr_ok, line_bad;

    assign pclk_rise = pclk_sync[1] & ~pclk_prev;
    assign hs_rise   = hs_sync[1] & ~hs_prev;
    assign hs_fall   = ~hs_sync[1] & hs_prev;
    assign vs_rise   = vs_sync[1] & ~vs_prev;
    assign vs_fall   = ~vs_sync[1] & vs_prev;
    assign cur_byte  = data_d2[7:0];
    assign raw       = swap_l ? {cur_byte, byte_a} : {byte_a, cur_byte};
    assign hc_inc    = (hc == 16'hFFFF) ? hc : hc + 16'd1;
    assign vc_inc    = (vc == 16'hFFFF) ? vc : vc + 16'd1;
    assign wr_ok     = ((hc & DEC_MASK) == 16'd0) && ((vc & DEC_MASK) == 16'd0)
                       && (hc < H_LIM) && (vc < V_LIM);
    assign line_bad  = (hc != H_LIM);

    always_comb begin
        conv = raw;
        case (fmt_l)
            2'd1:    conv = {raw[14:10], raw[9:5], raw[9], raw[4:0]};
            2'd2:    conv = {raw[11:8], raw[11], raw[7:4], raw[7:6], raw[3:0], raw[3]};
            default: conv = raw;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state      <= S_IDLE;
            en_xclk    <= 1'b0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_cnt  <= '0;
            byte_a     <= '0;
            pixel_data <= '0;
            hc         <= '0;
            vc         <= '0;
            h_addr     <= '0;
            v_addr     <= '0;
            fmt_l      <= '0;
            swap_l     <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            if (bus.i_stop) begin
                state   <= S_IDLE;
                en_xclk <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (bus.i_start_capture) begin
                        state   <= S_WAIT_VS_FALL;
                        en_xclk <= 1'b1;
                    end
                    S_WAIT_VS_FALL: if (vs_fall) begin
                        state    <= S_WAIT_HREF;
                        hc       <= '0;
                        vc       <= '0;
                        line_err <= 1'b0;
                        fmt_l    <= bus.i_fmt;
                        swap_l   <= bus.i_swap_bytes;
                    end
                    S_WAIT_HREF: begin
                        if (vs_rise) begin
                            state      <= S_FRAME_DONE;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            if (vc != V_LIM) line_err <= 1'b1;
                        end else if (hs_rise) begin
                            state <= S_BYTE0;
                            hc    <= '0;
                        end
                    end
                    S_BYTE0, S_BYTE1: begin
                        if (hs_fall) begin
                            // Line end is accounted before a coincident VS rise closes the frame
                            vc <= vc_inc;
                            if (line_bad || state == S_BYTE1) line_err <= 1'b1;
                            if (vs_rise) begin
                                state      <= S_FRAME_DONE;
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + 8'd1;
                                if (vc_inc != V_LIM) line_err <= 1'b1;
                            end else begin
                                state <= S_WAIT_HREF;
                            end
                        end else if (pclk_rise) begin
                            if (state == S_BYTE0) begin
                                byte_a <= cur_byte;
                                state  <= S_BYTE1;
                            end else begin
                                state <= S_BYTE0;
                                hc    <= hc_inc;
                                if (wr_ok) begin
                                    valid      <= 1'b1;
                                    pixel_data <= conv;
                                    h_addr     <= HA_W'(hc >> DEC_SH);
                                    v_addr     <= VA_W'(vc >> DEC_SH);
                                end
                            end
                        end
                    end
                    S_FRAME_DONE: if (bus.i_continuous || bus.i_start_capture) begin
                        state <= S_WAIT_VS_FALL;
                    end
                    default: begin
                        state   <= S_IDLE;
                        en_xclk <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_en_xclk    = en_xclk;
    assign bus.o_state      = state;
    assign bus.o_pixel_data = pixel_data;
    assign bus.o_h_addr     = h_addr;
    assign bus.o_v_addr     = v_addr;
    assign bus.o_valid      = valid;
    assign bus.o_frame_done = frame_done;
    assign bus.o_frame_cnt  = frame_cnt;
    assign bus.o_line_err   = line_err;
endmodule

// File: tb/tb_pixel_capture_engine.sv
// tb/tb_pixel_capture_engine.sv - scoreboard bench for pixel_capture_engine, 4x2/D1 and 8x4/D2 instances
module tb_pixel_capture_engine;
    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, stop = 1'b0, cont = 1'b0, swap = 1'b0;
    logic       pclk = 1'b0, vs = 1'b1, hs = 1'b0;
    logic [1:0] fmt = 2'd0;
    logic [7:0] data = 8'd0;

    pixel_capture_engine_if #(.DATA_WIDTH(8), .H_WIDTH(4), .V_WIDTH(2), .DECIM(1)) bus1 ();
    pixel_capture_engine_if #(.DATA_WIDTH(8), .H_WIDTH(8), .V_WIDTH(4), .DECIM(2)) bus2 ();

    assign bus1.i_start_capture = start;
    assign bus1.i_stop          = stop;
    assign bus1.i_continuous    = cont;
    assign bus1.i_fmt           = fmt;
    assign bus1.i_swap_bytes    = swap;
    assign bus1.i_PCLK          = pclk;
    assign bus1.i_VS            = vs;
    assign bus1.i_HS            = hs;
    assign bus1.i_DATA          = data;
    assign bus2.i_start_capture = start;
    assign bus2.i_stop          = stop;
    assign bus2.i_continuous    = cont;
    assign bus2.i_fmt           = fmt;
    assign bus2.i_swap_bytes    = swap;
    assign bus2.i_PCLK          = pclk;
    assign bus2.i_VS            = vs;
    assign bus2.i_HS            = hs;
    assign bus2.i_DATA          = data;

    pixel_capture_engine #(.DATA_WIDTH(8), .H_WIDTH(4), .V_WIDTH(2), .DECIM(1)) dut1 (
        .i_clk(clk), .i_n_reset(n_reset), .bus(bus1));
    pixel_capture_engine #(.DATA_WIDTH(8), .H_WIDTH(8), .V_WIDTH(4), .DECIM(2)) dut2 (
        .i_clk(clk), .i_n_reset(n_reset), .bus(bus2));

    int checks = 0, passes = 0;
    int vcnt1 = 0, vcnt2 = 0, fd1 = 0, fd2 = 0;
    logic [15:0] last_pix1 = '0;
    logic [7:0]  last_h2 = '0, last_v2 = '0;
    logic [31:0] q1[$], q2[$];

    bit          armed = 1'b0, capturing = 1'b0, parity = 1'b0, frame_swap = 1'b0;
    int          m_hc = 0, m_vc = 0;
    logic [7:0]  m_a = '0, exp_fc = '0;
    logic [1:0]  frame_fmt = '0;

    function automatic logic [15:0] model_pix(logic [7:0] a, logic [7:0] b, logic [1:0] f, bit s);
        logic [15:0] p;
        p = s ? {b, a} : {a, b};
        case (f)
            2'd1:    return {p[14:10], {p[9:5], p[9]}, p[4:0]};
            2'd2:    return {{p[11:8], p[11]}, {p[7:4], p[7:6]}, {p[3:0], p[3]}};
            default: return p;
        endcase
    endfunction

    function automatic logic [7:0] gen_byte(int pat, int ln, int idx);
        case (pat)
            0:       return (idx % 2 == 0) ? 8'h12 : 8'h34;
            1:       return (idx % 2 == 0) ? 8'h0F : 8'h8C;
            2:       return (idx % 2 == 0) ? 8'h8C : 8'h0F;
            default: return (idx % 2 == 0) ? 8'(ln * 16 + idx / 2) : (8'hA5 ^ 8'(idx / 2));
        endcase
    endfunction

    always @(negedge clk) begin
        logic [31:0] exp_w, got_w;
        if (bus1.o_frame_done) fd1++;
        if (bus2.o_frame_done) fd2++;
        if (bus1.o_valid) begin
            vcnt1++;
            last_pix1 = bus1.o_pixel_data;
            got_w = {bus1.o_pixel_data, 8'(bus1.o_h_addr), 8'(bus1.o_v_addr)};
            checks++;
            if (q1.size() == 0) $display("FAIL dut1_unexpected_write got=%h required=none", got_w);
            else begin
                exp_w = q1.pop_front();
                if (got_w !== exp_w) $display("FAIL dut1_write got=%h required=%h", got_w, exp_w);
                else passes++;
            end
        end
        if (bus2.o_valid) begin
            vcnt2++;
            last_h2 = 8'(bus2.o_h_addr);
            last_v2 = 8'(bus2.o_v_addr);
            got_w = {bus2.o_pixel_data, 8'(bus2.o_h_addr), 8'(bus2.o_v_addr)};
            checks++;
            if (q2.size() == 0) $display("FAIL dut2_unexpected_write got=%h required=none", got_w);
            else begin
                exp_w = q2.pop_front();
                if (got_w !== exp_w) $display("FAIL dut2_write got=%h required=%h", got_w, exp_w);
                else passes++;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        armed = 1'b1;
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        armed = 1'b0;
        capturing = 1'b0;
    endtask

    task automatic cam_byte(logic [7:0] b);
        logic [15:0] pix;
        data = b;
        #20 pclk = 1'b1;
        if (!parity) m_a = b;
        else begin
            if (capturing) begin
                pix = model_pix(m_a, b, frame_fmt, frame_swap);
                if (m_hc < 4 && m_vc < 2) q1.push_back({pix, 8'(m_hc), 8'(m_vc)});
                if (m_hc % 2 == 0 && m_vc % 2 == 0 && m_hc < 8 && m_vc < 4)
                    q2.push_back({pix, 8'(m_hc / 2), 8'(m_vc / 2)});
            end
            m_hc++;
        end
        parity = ~parity;
        #20 pclk = 1'b0;
    endtask

    task automatic line_begin();
        hs = 1'b1;
        m_hc = 0;
        parity = 1'b0;
        #40;
    endtask

    task automatic line_end();
        hs = 1'b0;
        m_vc++;
        #40;
    endtask

    task automatic send_line(int nbytes, int pat);
        line_begin();
        for (int i = 0; i < nbytes; i++) cam_byte(gen_byte(pat, m_vc, i));
        line_end();
    endtask

    task automatic frame_begin();
        vs = 1'b0;
        capturing = armed;
        frame_fmt = fmt;
        frame_swap = swap;
        m_vc = 0;
        #60;
    endtask

    task automatic frame_end();
        #40 vs = 1'b1;
        #100;
        if (capturing) begin
            exp_fc = exp_fc + 8'd1;
            if (!cont) armed = 1'b0;
        end
        capturing = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        #23;
        checks++; if (bus1.o_state !== 6'b000001) $display("FAIL reset_state got=%b required=000001", bus1.o_state); else passes++;
        checks++; if (bus1.o_en_xclk !== 1'b0) $display("FAIL reset_en_xclk got=%b required=0", bus1.o_en_xclk); else passes++;
        checks++; if (bus1.o_valid !== 1'b0) $display("FAIL reset_valid got=%b required=0", bus1.o_valid); else passes++;
        checks++; if (bus1.o_frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b required=0", bus1.o_frame_done); else passes++;
        checks++; if (bus1.o_frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt got=%0d required=0", bus1.o_frame_cnt); else passes++;
        checks++; if (bus1.o_line_err !== 1'b0) $display("FAIL reset_line_err got=%b required=0", bus1.o_line_err); else passes++;
        checks++; if (bus1.o_pixel_data !== 16'd0) $display("FAIL reset_pixel got=%h required=0000", bus1.o_pixel_data); else passes++;
        checks++; if ({bus1.o_h_addr, bus1.o_v_addr} !== 3'd0) $display("FAIL reset_addr got=%0d required=0", {bus1.o_h_addr, bus1.o_v_addr}); else passes++;
        @(negedge clk) n_reset = 1'b1;
        #60;
        checks++; if (bus2.o_state !== 6'b000001) $display("FAIL idle_without_start got=%b required=000001", bus2.o_state); else passes++;
        exp_fc = '0;
    endtask

    task automatic test_rgb565();
        int v0 = vcnt1, f0 = fd1;
        fmt = 2'd0; swap = 1'b0; cont = 1'b0;
        pulse_start();
        frame_begin();
        send_line(8, 0);
        send_line(8, 0);
        frame_end();
        checks++; if (vcnt1 - v0 !== 8) $display("FAIL rgb565_writes got=%0d required=8", vcnt1 - v0); else passes++;
        checks++; if (q1.size() !== 0) $display("FAIL rgb565_pending got=%0d required=0", q1.size()); else passes++;
        checks++; if (fd1 - f0 !== 1) $display("FAIL rgb565_frame_done got=%0d required=1", fd1 - f0); else passes++;
        checks++; if (bus1.o_frame_cnt !== 8'd1) $display("FAIL rgb565_frame_cnt got=%0d required=1", bus1.o_frame_cnt); else passes++;
        checks++; if (bus1.o_line_err !== 1'b0) $display("FAIL rgb565_line_err got=%b required=0", bus1.o_line_err); else passes++;
        checks++; if (last_pix1 !== 16'h1234) $display("FAIL rgb565_pixel got=%h required=1234", last_pix1); else passes++;
        checks++; if (bus1.o_en_xclk !== 1'b1) $display("FAIL rgb565_en_xclk got=%b required=1", bus1.o_en_xclk); else passes++;
        checks++; if (bus1.o_state !== 6'b100000) $display("FAIL rgb565_state got=%b required=100000", bus1.o_state); else passes++;
    endtask

    task automatic test_formats();
        logic [1:0]  fl[3] = '{2'd2, 2'd2, 2'd1};
        bit          sl[3] = '{1'b0, 1'b1, 1'b0};
        int          pl[3] = '{1, 2, 0};
        logic [15:0] wl[3] = '{16'hFC59, 16'hFC59, 16'h2474};
        for (int i = 0; i < 3; i++) begin
            fmt = fl[i]; swap = sl[i];
            pulse_start();
            frame_begin();
            send_line(8, pl[i]);
            send_line(8, pl[i]);
            frame_end();
            checks++; if (last_pix1 !== wl[i]) $display("FAIL format_%0d_pixel got=%h required=%h", i, last_pix1, wl[i]); else passes++;
        end
        fmt = 2'd0; swap = 1'b0;
    endtask

    task automatic test_decim();
        int v0 = vcnt2;
        pulse_start();
        frame_begin();
        for (int l = 0; l < 4; l++) send_line(16, 3);
        frame_end();
        checks++; if (vcnt2 - v0 !== 8) $display("FAIL decim_writes got=%0d required=8", vcnt2 - v0); else passes++;
        checks++; if (q2.size() !== 0) $display("FAIL decim_pending got=%0d required=0", q2.size()); else passes++;
        checks++; if (last_h2 !== 8'd3 || last_v2 !== 8'd1) $display("FAIL decim_last_addr got=%0d,%0d required=3,1", last_h2, last_v2); else passes++;
        checks++; if (bus2.o_line_err !== 1'b0) $display("FAIL decim_line_err got=%b required=0", bus2.o_line_err); else passes++;
        checks++; if (bus1.o_line_err !== 1'b1) $display("FAIL oversize_line_err got=%b required=1", bus1.o_line_err); else passes++;
        checks++; if (bus1.o_frame_cnt !== exp_fc) $display("FAIL decim_frame_cnt got=%0d required=%0d", bus1.o_frame_cnt, exp_fc); else passes++;
    endtask

    task automatic test_line_err();
        int v0 = vcnt1;
        pulse_start();
        frame_begin();
        send_line(7, 0);
        checks++; if (bus1.o_line_err !== 1'b1) $display("FAIL odd_line_err got=%b required=1", bus1.o_line_err); else passes++;
        send_line(8, 0);
        frame_end();
        checks++; if (vcnt1 - v0 !== 7) $display("FAIL odd_line_writes got=%0d required=7", vcnt1 - v0); else passes++;
        checks++; if (bus1.o_line_err !== 1'b1) $display("FAIL line_err_sticky got=%b required=1", bus1.o_line_err); else passes++;
        pulse_start();
        frame_begin();
        checks++; if (bus1.o_line_err !== 1'b0) $display("FAIL line_err_clear got=%b required=0", bus1.o_line_err); else passes++;
        send_line(8, 0);
        send_line(8, 0);
        frame_end();
        checks++; if (bus1.o_line_err !== 1'b0) $display("FAIL clean_frame_err got=%b required=0", bus1.o_line_err); else passes++;
    endtask

    task automatic test_continuous_stop();
        int f0 = fd1, v0;
        cont = 1'b1;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            frame_begin();
            send_line(8, 0);
            send_line(8, 0);
            frame_end();
        end
        checks++; if (fd1 - f0 !== 3) $display("FAIL cont_frame_done got=%0d required=3", fd1 - f0); else passes++;
        checks++; if (bus1.o_frame_cnt !== exp_fc) $display("FAIL cont_frame_cnt got=%0d required=%0d", bus1.o_frame_cnt, exp_fc); else passes++;
        checks++; if (bus1.o_state !== 6'b000010) $display("FAIL cont_rearm_state got=%b required=000010", bus1.o_state); else passes++;
        v0 = vcnt1;
        frame_begin();
        line_begin();
        cam_byte(8'h12);
        cam_byte(8'h34);
        #40;
        pulse_stop();
        for (int i = 0; i < 4; i++) cam_byte(gen_byte(0, m_vc, i));
        line_end();
        frame_end();
        checks++; if (vcnt1 - v0 !== 1) $display("FAIL stop_writes got=%0d required=1", vcnt1 - v0); else passes++;
        checks++; if (bus1.o_state !== 6'b000001) $display("FAIL stop_state got=%b required=000001", bus1.o_state); else passes++;
        checks++; if (bus1.o_en_xclk !== 1'b0) $display("FAIL stop_en_xclk got=%b required=0", bus1.o_en_xclk); else passes++;
        checks++; if (bus1.o_frame_cnt !== exp_fc) $display("FAIL stop_frame_cnt got=%0d required=%0d", bus1.o_frame_cnt, exp_fc); else passes++;
        cont = 1'b0;
    endtask

    task automatic test_reset_midline();
        int v0, f0;
        pulse_start();
        frame_begin();
        line_begin();
        cam_byte(8'h12);
        cam_byte(8'h34);
        #40;
        v0 = vcnt1; f0 = fd1;
        #3 n_reset = 1'b0;
        armed = 1'b0; capturing = 1'b0; exp_fc = '0;
        #1;
        checks++; if (bus1.o_state !== 6'b000001) $display("FAIL rst_mid_state got=%b required=000001", bus1.o_state); else passes++;
        checks++; if (bus1.o_en_xclk !== 1'b0) $display("FAIL rst_mid_en_xclk got=%b required=0", bus1.o_en_xclk); else passes++;
        checks++; if (bus1.o_pixel_data !== 16'd0) $display("FAIL rst_mid_pixel got=%h required=0000", bus1.o_pixel_data); else passes++;
        checks++; if (bus1.o_frame_cnt !== 8'd0) $display("FAIL rst_mid_frame_cnt got=%0d required=0", bus1.o_frame_cnt); else passes++;
        @(negedge clk) n_reset = 1'b1;
        for (int i = 0; i < 4; i++) cam_byte(gen_byte(0, m_vc, i));
        line_end();
        send_line(8, 0);
        frame_end();
        checks++; if (vcnt1 !== v0) $display("FAIL rst_mid_writes got=%0d required=%0d", vcnt1, v0); else passes++;
        checks++; if (fd1 !== f0) $display("FAIL rst_mid_frame_done got=%0d required=%0d", fd1, f0); else passes++;
        checks++; if (bus1.o_state !== 6'b000001) $display("FAIL rst_mid_no_rearm got=%b required=000001", bus1.o_state); else passes++;
        checks++; if (q1.size() + q2.size() !== 0) $display("FAIL final_pending got=%0d required=0", q1.size() + q2.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_rgb565();
        test_formats();
        test_decim();
        test_line_err();
        test_continuous_stop();
        test_reset_midline();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
